// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
package alu_arbiter_pkg;

   // Arbiter FSM: accept a request, wait out the ALU latency, then present the response.
   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StWait = 2'd1,
      StResp = 2'd2
   } state_e;

   localparam logic [2:0] OP_DIV     = 3'd3;
   localparam logic       MODE_ARITH = 1'b1;

   // Only the arithmetic divide takes the long ALU path; every other code is single-cycle.
   function automatic logic is_div(input logic mode, input logic [2:0] op);
      return (mode == MODE_ARITH) && (op == OP_DIV);
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: the requester named by ptr has priority.
module rr_arb2 (
   input  logic [1:0] valid,
   input  logic       ptr,
   output logic [1:0] grant
);

   // Priority requester wins if valid, otherwise the other one if valid.
   always_comb begin
      grant = 2'b00;
      if (valid[ptr]) begin
         grant[ptr] = 1'b1;
      end else if (valid[~ptr]) begin
         grant[~ptr] = 1'b1;
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters, one operation in flight at a time.
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int unsigned DWIDTH  = 8,
   parameter int unsigned DIV_LAT = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            req_valid,
   output logic [1:0]            req_ready,
   input  logic [1:0]            req_mode,
   input  logic [5:0]            req_op,
   input  logic [2*DWIDTH-1:0]   req_a,
   input  logic [2*DWIDTH-1:0]   req_b,
   output logic                  alu_mode,
   output logic [2:0]            alu_op,
   output logic [DWIDTH-1:0]     alu_din1,
   output logic [DWIDTH-1:0]     alu_din2,
   input  logic [2*DWIDTH-1:0]   alu_result,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic                  resp_id,
   output logic [2*DWIDTH-1:0]   resp_data,
   output logic                  busy
);

   localparam int unsigned CW = $clog2(DIV_LAT + 1);

   state_e              state_q, state_d;
   logic                ptr_q;
   logic [CW-1:0]       cnt_q;
   logic                alu_mode_q;
   logic [2:0]          alu_op_q;
   logic [DWIDTH-1:0]   alu_din1_q, alu_din2_q;
   logic                resp_valid_q, resp_id_q;
   logic [2*DWIDTH-1:0] resp_data_q;

   logic [1:0]          grant;
   logic [1:0]          ready;
   logic                accept;
   logic                acc_id;
   logic                sel_mode;
   logic [2:0]          sel_op;
   logic [DWIDTH-1:0]   sel_a, sel_b;
   logic [CW-1:0]       sel_lat;

   rr_arb2 u_rr_arb2 (
      .valid (req_valid),
      .ptr   (ptr_q),
      .grant (grant)
   );

   // Grants are only offered while idle; the winner's fields are muxed for latching.
   always_comb begin
      ready    = (state_q == StIdle) ? grant : 2'b00;
      accept   = |(req_valid & ready);
      acc_id   = ready[1];
      sel_mode = req_mode[acc_id];
      sel_op   = acc_id ? req_op[5:3] : req_op[2:0];
      sel_a    = acc_id ? req_a[2*DWIDTH-1:DWIDTH] : req_a[DWIDTH-1:0];
      sel_b    = acc_id ? req_b[2*DWIDTH-1:DWIDTH] : req_b[DWIDTH-1:0];
      sel_lat  = is_div(sel_mode, sel_op) ? CW'(DIV_LAT) : CW'(1);
   end

   // Next-state: accept -> wait for counter to drain -> hold response until taken.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (accept) state_d = StWait;
         StWait:  if (cnt_q == '0) state_d = StResp;
         StResp:  if (resp_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // State, pointer, latency counter, ALU operand and response registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         ptr_q        <= 1'b0;
         cnt_q        <= '0;
         alu_mode_q   <= 1'b0;
         alu_op_q     <= 3'd0;
         alu_din1_q   <= '0;
         alu_din2_q   <= '0;
         resp_valid_q <= 1'b0;
         resp_id_q    <= 1'b0;
         resp_data_q  <= '0;
      end else begin
         state_q <= state_d;
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  alu_mode_q <= sel_mode;
                  alu_op_q   <= sel_op;
                  alu_din1_q <= sel_a;
                  alu_din2_q <= sel_b;
                  resp_id_q  <= acc_id;
                  ptr_q      <= ~acc_id;
                  cnt_q      <= sel_lat;
               end
            end
            StWait: begin
               if (cnt_q == '0) begin
                  resp_data_q  <= alu_result;
                  resp_valid_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            StResp: begin
               if (resp_ready) resp_valid_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign req_ready  = ready;
   assign alu_mode   = alu_mode_q;
   assign alu_op     = alu_op_q;
   assign alu_din1   = alu_din1_q;
   assign alu_din2   = alu_din2_q;
   assign resp_valid = resp_valid_q;
   assign resp_id    = resp_id_q;
   assign resp_data  = resp_data_q;
   assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed plus randomized bench for alu_arbiter with a behavioural ALU and arbiter model.
module tb_alu_arbiter;

   localparam int DW = 8;
   localparam int DL = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [1:0]    req_valid = '0;
   logic [1:0]    req_ready;
   logic [1:0]    req_mode = '0;
   logic [5:0]    req_op = '0;
   logic [15:0]   req_a = '0;
   logic [15:0]   req_b = '0;
   logic          alu_mode;
   logic [2:0]    alu_op;
   logic [7:0]    alu_din1, alu_din2;
   logic [15:0]   alu_result = '0;
   logic          resp_valid;
   logic          resp_ready = 1'b0;
   logic          resp_id;
   logic [15:0]   resp_data;
   logic          busy;

   int n_vec  = 0;
   int n_fail = 0;
   int ptr_m  = 0;
   int alu_age = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.DWIDTH(DW), .DIV_LAT(DL)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_mode   (req_mode),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .alu_mode   (alu_mode),
      .alu_op     (alu_op),
      .alu_din1   (alu_din1),
      .alu_din2   (alu_din2),
      .alu_result (alu_result),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_id    (resp_id),
      .resp_data  (resp_data),
      .busy       (busy)
   );

   // Behavioural ALU function: arithmetic add/sub/mul/div, logic and/or/xor/not.
   function automatic logic [15:0] alu_f(input logic m, input logic [2:0] op,
                                         input logic [7:0] a, input logic [7:0] b);
      if (m) begin
         case (op)
            3'd0: return {8'd0, a} + {8'd0, b};
            3'd1: return {8'd0, a} - {8'd0, b};
            3'd2: return {8'd0, a} * {8'd0, b};
            3'd3: return (b == 8'd0) ? 16'hFFFF : {8'd0, a / b};
            default: return 16'd0;
         endcase
      end else begin
         case (op)
            3'd0: return {8'd0, a & b};
            3'd1: return {8'd0, a | b};
            3'd2: return {8'd0, a ^ b};
            3'd3: return {8'd0, ~a};
            default: return 16'd0;
         endcase
      end
   endfunction

   function automatic int alu_need(input logic m, input logic [2:0] op);
      return (m && op == 3'd3) ? DL : 1;
   endfunction

   // ALU model: result is garbage until the operands have been applied long enough.
   always @(posedge clk) begin
      alu_age    <= (|(req_valid & req_ready)) ? 0 : ((alu_age < 1000) ? alu_age + 1 : alu_age);
      alu_result <= ((|(req_valid & req_ready)) ? 0 : alu_age + 1) >= alu_need(alu_mode, alu_op)
                    ? alu_f(alu_mode, alu_op, alu_din1, alu_din2) : 16'hDEAD;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_valid = '0;
      resp_ready = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("reset_state", {alu_mode, alu_op, alu_din1, alu_din2, resp_valid, resp_id,
                          resp_data, busy, req_ready}, 64'd0);
      rst = 1'b0;
      ptr_m = 0;
   endtask

   // One full transaction: grant, accept, latency, response hold, release.
   task automatic round(input logic [1:0] vm, input logic [1:0] md, input logic [5:0] op,
                        input logic [15:0] a, input logic [15:0] b, input int hold);
      int w, lat, n;
      logic wm;
      logic [2:0] wop;
      logic [7:0] wa, wb;
      logic [15:0] exp;
      logic [1:0] rest;
      req_valid = vm; req_mode = md; req_op = op; req_a = a; req_b = b;
      #1;
      w   = (vm == 2'b11) ? ptr_m : (vm[1] ? 1 : 0);
      wm  = md[w];
      wop = op[3*w +: 3];
      wa  = a[8*w +: 8];
      wb  = b[8*w +: 8];
      exp = alu_f(wm, wop, wa, wb);
      lat = alu_need(wm, wop) + 1;
      chk("grant", req_ready, 64'(2'b01 << w));
      chk("idle_busy", busy, 64'd0);
      @(posedge clk);
      #1;
      ptr_m = 1 - w;
      rest = vm;
      rest[w] = 1'b0;
      req_valid = rest;
      chk("alu_fields", {alu_mode, alu_op, alu_din1, alu_din2}, {wm, wop, wa, wb});
      chk("wait_ready", {req_ready, busy}, 64'b001);
      n = 0;
      while (resp_valid !== 1'b1 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("latency", n, lat);
      chk("resp_id", resp_id, w);
      chk("resp_data", resp_data, exp);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         #1;
         chk("resp_hold", {resp_valid, resp_id, resp_data, req_ready, alu_din1, alu_din2},
             {1'b1, w[0], exp, 2'b00, wa, wb});
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      chk("released", {resp_valid, busy}, 64'd0);
      chk("post_ready", req_ready, rest);
      req_valid = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      logic [1:0] vm, md;
      logic [5:0] op;
      do_reset();

      // Single arithmetic add from requester 0.
      round(2'b01, 2'b01, 6'o00, {8'd0, 8'd200}, {8'd0, 8'd100}, 0);

      // Simultaneous requests right after reset: req0 add first, then req1 xor.
      do_reset();
      round(2'b11, 2'b01, {3'd2, 3'd0}, {8'h0F, 8'd5}, {8'hFF, 8'd3}, 0);
      round(2'b10, 2'b01, {3'd2, 3'd0}, {8'h0F, 8'd5}, {8'hFF, 8'd3}, 0);

      // Response held 5 cycles while the other requester stays valid.
      round(2'b11, 2'b11, {3'd3, 3'd1}, {8'd100, 8'd50}, {8'd7, 8'd8}, 5);
      // Divide from requester 1, long latency.
      round(2'b10, 2'b10, {3'd3, 3'd0}, {8'd100, 8'd0}, {8'd7, 8'd0}, 2);

      // Reset pulse in the middle of a divide.
      req_valid = 2'b01; req_mode = 2'b01; req_op = 6'o03; req_a = 16'd100; req_b = 16'd7;
      #1;
      chk("div_grant", req_ready, 64'd1);
      @(posedge clk);
      #1;
      req_valid = 2'b00;
      ptr_m = 1;
      repeat (4) @(posedge clk);
      #1;
      chk("mid_wait_busy", busy, 64'd1);
      #2 rst = 1'b1;
      #1;
      chk("async_reset", {busy, resp_valid, alu_mode, alu_op, alu_din1, alu_din2}, 64'd0);
      rst = 1'b0;
      ptr_m = 0;
      seen = 0;
      repeat (25) begin
         @(posedge clk);
         #1;
         if (resp_valid !== 1'b0 || busy !== 1'b0) seen++;
      end
      chk("no_resp_after_reset", seen, 64'd0);
      round(2'b11, 2'b00, {3'd1, 3'd0}, {8'hA5, 8'h3C}, {8'h0F, 8'hF0}, 1);

      // Randomized traffic.
      for (int i = 0; i < 40; i++) begin
         vm = 2'($urandom_range(1, 3));
         md = 2'($urandom);
         op = 6'($urandom);
         if ($urandom_range(0, 3) == 0) begin
            md = 2'b11;
            op = {3'd3, 3'd3};
         end
         round(vm, md, op, 16'($urandom), 16'($urandom), int'($urandom_range(0, 3)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
